// File: rtl/ioctl_loader.sv
// ioctl_loader: routes the HPS ioctl byte stream to one of NCH memories and
// strips magic-tagged headers. Optional checksum: IOCTL_LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module ioctl_loader #(
    parameter int              NCH         = 2,
    parameter int              AW          = 18,
    parameter int              HDR_LEN     = 128,
    parameter logic [NCH-1:0]  HDR_CH_MASK = 2'b10,
    parameter logic [39:0]     MAGIC       = 40'h4154415249,
    parameter int              CAP_OFF     = 49,
    parameter int              CAP_LEN     = 10,
    localparam int             CW          = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 ioctl_download,
    input  logic [7:0]           ioctl_index,
    input  logic [24:0]          ioctl_addr,
    input  logic [7:0]           ioctl_dout,
    input  logic                 ioctl_wr,
    output logic                 ioctl_wait,
    output logic [NCH-1:0]       mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [7:0]           mem_data,
    input  logic                 mem_ready,
    output logic                 load_active,
    output logic [CW-1:0]        load_ch,
    output logic                 load_done,
    output logic                 hdr_valid,
    output logic [8*CAP_LEN-1:0] hdr_info,
    output logic [31:0]          load_size,
    output logic                 err
`ifdef IOCTL_LOADER_CHECKSUM_EN
    ,
    output logic [7:0]           checksum
`endif
);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t               state_q, state_d;
    logic                 dl_q;
    logic                 pend_q, pend_d;
    logic [CW-1:0]        ch_q, ch_d;
    logic [NCH-1:0]       we_q, we_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [7:0]           data_q, data_d;
    logic                 act_q, act_d;
    logic                 done_q, done_d;
    logic                 hv_q, hv_d;
    logic [8*CAP_LEN-1:0] info_q, info_d;
    logic [31:0]          size_q, size_d;
    logic                 err_q, err_d;
    logic [4:0]           mag_q, mag_d;
    logic [24:0]          last_q, last_d;
    logic                 any_q, any_d;
`ifdef IOCTL_LOADER_CHECKSUM_EN
    logic [7:0]           sall_q, sall_d;
    logic [7:0]           spay_q, spay_d;
    logic [7:0]           cks_q, cks_d;
`endif

    logic        rise, fall, acc, start, fin;
    logic [25:0] tot, sub;
    logic [31:0] sz;

    assign ioctl_wait = (|we_q) & ~mem_ready;

    always_comb begin
        rise    = ioctl_download & ~dl_q;
        fall    = ~ioctl_download & dl_q;
        acc     = ioctl_wr && (state_q == ACTIVE) && !ioctl_wait;
        start   = 1'b0;
        fin     = 1'b0;
        state_d = state_q;
        pend_d  = pend_q;
        ch_d    = ch_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        act_d   = act_q;
        done_d  = 1'b0;
        hv_d    = hv_q;
        info_d  = info_q;
        size_d  = size_q;
        err_d   = err_q;
        mag_d   = mag_q;
        last_d  = last_q;
        any_d   = any_q;
`ifdef IOCTL_LOADER_CHECKSUM_EN
        sall_d  = sall_q;
        spay_d  = spay_q;
        cks_d   = cks_q;
`endif
        if (mem_ready) we_d = '0;
        if (ioctl_wr && (state_q == ACTIVE) && ioctl_wait) err_d = 1'b1;

        if (acc) begin
            we_d       = '0;
            we_d[ch_q] = 1'b1;
            addr_d     = (hv_q && ioctl_addr >= 25'(HDR_LEN))
                       ? AW'(ioctl_addr - 25'(HDR_LEN))
                       : AW'(ioctl_addr);
            data_d     = ioctl_dout;
            last_d     = ioctl_addr;
            any_d      = 1'b1;
            for (int k = 0; k < 5; k++)
                if (ioctl_addr == 25'(k + 1))
                    mag_d[k] = (ioctl_dout == MAGIC[39-8*k -: 8]);
            if (ioctl_addr == 25'd5)
                hv_d = (&mag_d) && HDR_CH_MASK[ch_q];
            for (int i = 0; i < CAP_LEN; i++)
                if (ioctl_addr == 25'(CAP_OFF + i))
                    info_d[8*(CAP_LEN-1-i) +: 8] = ioctl_dout;
`ifdef IOCTL_LOADER_CHECKSUM_EN
            // Both sums run because the header verdict arrives at offset 5
            sall_d = sall_q + ioctl_dout;
            if (ioctl_addr >= 25'(HDR_LEN)) spay_d = spay_q + ioctl_dout;
`endif
        end

        tot = 26'(last_q) + 26'd1;
        sub = hv_q ? 26'(HDR_LEN) : 26'd0;
        sz  = (!any_q || tot < sub) ? 32'd0 : 32'(tot - sub);

        unique case (state_q)
            IDLE:   start = rise || (pend_q && ioctl_download);
            ACTIVE: if (fall) begin
                        if (|we_d) state_d = DRAIN;
                        else       fin     = 1'b1;
                    end
            DRAIN:  begin
                        if (!(|we_d)) fin    = 1'b1;
                        if (rise)     pend_d = 1'b1;
                    end
            default: state_d = IDLE;
        endcase

        if (fin) begin
            state_d = IDLE;
            act_d   = 1'b0;
            done_d  = 1'b1;
            size_d  = sz;
`ifdef IOCTL_LOADER_CHECKSUM_EN
            cks_d   = hv_q ? spay_q : sall_q;
`endif
        end

        if (start) begin
            state_d = ACTIVE;
            pend_d  = 1'b0;
            act_d   = 1'b1;
            ch_d    = (32'(ioctl_index) >= NCH) ? CW'(NCH - 1) : CW'(ioctl_index);
            hv_d    = 1'b0;
            info_d  = '0;
            err_d   = 1'b0;
            mag_d   = '0;
            last_d  = '0;
            any_d   = 1'b0;
`ifdef IOCTL_LOADER_CHECKSUM_EN
            sall_d  = '0;
            spay_d  = '0;
            cks_d   = '0;
`endif
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q <= IDLE;
            dl_q    <= 1'b1;
            pend_q  <= 1'b0;
            ch_q    <= '0;
            we_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            act_q   <= 1'b0;
            done_q  <= 1'b0;
            hv_q    <= 1'b0;
            info_q  <= '0;
            size_q  <= '0;
            err_q   <= 1'b0;
            mag_q   <= '0;
            last_q  <= '0;
            any_q   <= 1'b0;
`ifdef IOCTL_LOADER_CHECKSUM_EN
            sall_q  <= '0;
            spay_q  <= '0;
            cks_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            dl_q    <= ioctl_download;
            pend_q  <= pend_d;
            ch_q    <= ch_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            act_q   <= act_d;
            done_q  <= done_d;
            hv_q    <= hv_d;
            info_q  <= info_d;
            size_q  <= size_d;
            err_q   <= err_d;
            mag_q   <= mag_d;
            last_q  <= last_d;
            any_q   <= any_d;
`ifdef IOCTL_LOADER_CHECKSUM_EN
            sall_q  <= sall_d;
            spay_q  <= spay_d;
            cks_q   <= cks_d;
`endif
        end
    end

    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_data    = data_q;
    assign load_active = act_q;
    assign load_ch     = ch_q;
    assign load_done   = done_q;
    assign hdr_valid   = hv_q;
    assign hdr_info    = info_q;
    assign load_size   = size_q;
    assign err         = err_q;
`ifdef IOCTL_LOADER_CHECKSUM_EN
    assign checksum    = cks_q;
`endif

endmodule

// File: tb/tb_ioctl_loader.sv
// Bench for ioctl_loader: directed plan steps plus random files checked
// against a file-level model of routing, header stripping and sizing.
`timescale 1ns/1ps
module tb_ioctl_loader;

    localparam int NCH = 2;
    localparam int AW  = 18;
    localparam int HL  = 128;
    localparam int CO  = 49;
    localparam int CL  = 10;

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic          ioctl_download;
    logic [7:0]    ioctl_index;
    logic [24:0]   ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic          ioctl_wr;
    logic          ioctl_wait;
    logic [NCH-1:0] mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic          mem_ready;
    logic          load_active;
    logic [0:0]    load_ch;
    logic          load_done;
    logic          hdr_valid;
    logic [8*CL-1:0] hdr_info;
    logic [31:0]   load_size;
    logic          err;
`ifdef IOCTL_LOADER_CHECKSUM_EN
    logic [7:0]    checksum;
`endif

    always #5 clk_sys = ~clk_sys;

    ioctl_loader dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wr(ioctl_wr), .ioctl_wait(ioctl_wait),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_ready(mem_ready), .load_active(load_active),
        .load_ch(load_ch), .load_done(load_done),
        .hdr_valid(hdr_valid), .hdr_info(hdr_info),
        .load_size(load_size), .err(err)
`ifdef IOCTL_LOADER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] file[$];

    task automatic chk(input string tag, input logic [79:0] obs,
                       input logic [79:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic fill(input int n);
        file.delete();
        for (int i = 0; i < n; i++) file.push_back(8'($urandom));
    endtask

    task automatic put_magic();
        file[1] = 8'h41; file[2] = 8'h54; file[3] = 8'h41;
        file[4] = 8'h52; file[5] = 8'h49;
    endtask

    // Whole-file model: expected route, stripped addresses, size, capture
    task automatic run_file(input logic [7:0] idx, input int gaps);
        int n, ch, sz, g;
        bit mg;
        logic [39:0] mag;
        logic [1:0] mask;
        logic [79:0] inf;
        logic [7:0] cks;
        logic [31:0] oa;
        logic [AW-1:0] ea;
        n = file.size();
        ch = (idx >= NCH) ? NCH - 1 : int'(idx);
        mag = 40'h4154415249;
        mask = 2'b10;
        mg = (mask[ch] == 1'b1) && (n > 5);
        for (int k = 0; k < 5; k++)
            if (mg && file[1+k] != mag[39-8*k -: 8]) mg = 1'b0;
        inf = '0;
        for (int i = 0; i < CL; i++)
            if (CO + i < n) inf[79-8*i -: 8] = file[CO+i];
        sz = mg ? ((n > HL) ? n - HL : 0) : n;
        cks = '0;
        for (int o = 0; o < n; o++)
            if (!mg || o >= HL) cks = cks + file[o];

        mem_ready = 1'b1;
        ioctl_index = idx;
        ioctl_download = 1'b1;
        cyc();
        chk("start_active", load_active, 1);
        chk("start_ch", load_ch, ch);
        for (int o = 0; o < n; o++) begin
            ioctl_addr = 25'(o);
            ioctl_dout = file[o];
            ioctl_wr = 1'b1;
            cyc();
            ioctl_wr = 1'b0;
            oa = (mg && o >= HL) ? 32'(o - HL) : 32'(o);
            ea = oa[AW-1:0];
            chk("byte_we", mem_we, 1 << ch);
            chk("byte_addr", mem_addr, ea);
            chk("byte_data", mem_data, file[o]);
            chk("byte_wait", ioctl_wait, 0);
            g = (gaps > 0) ? $urandom_range(0, gaps) : 0;
            if (g > 0) begin
                cyc(g);
                chk("gap_we", mem_we, 0);
            end
        end
        ioctl_download = 1'b0;
        cyc();
        chk("done_pulse", load_done, 1);
        chk("done_size", load_size, sz);
        chk("done_hdr_valid", hdr_valid, mg);
        chk("done_hdr_info", hdr_info, inf);
        chk("done_active", load_active, 0);
        chk("done_err", err, 0);
`ifdef IOCTL_LOADER_CHECKSUM_EN
        chk("done_checksum", checksum, cks);
`endif
        cyc();
        chk("done_drop", load_done, 0);
    endtask

    initial begin
        int wcnt;
        reset_n = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index = '0;
        ioctl_addr = '0;
        ioctl_dout = '0;
        ioctl_wr = 1'b0;
        mem_ready = 1'b1;
        cyc(3);
        chk("rst_we", mem_we, 0);
        chk("rst_active", load_active, 0);
        chk("rst_done", load_done, 0);
        chk("rst_hdr", hdr_valid, 0);
        chk("rst_info", hdr_info, 0);
        chk("rst_size", load_size, 0);
        chk("rst_err", err, 0);
        chk("rst_ch", load_ch, 0);
        chk("rst_wait", ioctl_wait, 0);
        reset_n = 1'b1;
        cyc();

        // Plain 4-byte load to channel 0
        file.delete();
        for (int i = 0; i < 4; i++) file.push_back(8'h11 + 8'(i));
        run_file(8'd0, 0);
        chk("t1_size", load_size, 4);

        // 132-byte file with header on channel 1
        fill(132);
        put_magic();
        file[49] = 8'hAB;
        run_file(8'd1, 0);
        chk("t2_info_msb", hdr_info[79:72], 8'hAB);
        chk("t2_size", load_size, 4);

        // 200 bytes, no magic
        fill(200);
        file[1] = 8'h00;
        run_file(8'd1, 0);
        chk("t3_size", load_size, 200);

        // Index beyond NCH clamps to last channel; magic still honoured
        fill(150);
        put_magic();
        run_file(8'd7, 1);

        // Magic on a channel without header stripping
        fill(140);
        put_magic();
        run_file(8'd0, 0);

        // Short header-tagged file: size saturates at 0
        fill(20);
        put_magic();
        run_file(8'd1, 0);

        // Back-pressure: ready low for 3 cycles on 2nd byte, extra byte dropped
        mem_ready = 1'b1;
        ioctl_index = 8'd0;
        ioctl_download = 1'b1;
        cyc();
        ioctl_addr = 25'd0; ioctl_dout = 8'h21; ioctl_wr = 1'b1;
        cyc();
        chk("st_b0_addr", mem_addr, 0);
        ioctl_addr = 25'd1; ioctl_dout = 8'h22;
        cyc();
        chk("st_b1_we", mem_we, 2'b01);
        mem_ready = 1'b0;
        ioctl_addr = 25'd2; ioctl_dout = 8'h99;
        #1;
        wcnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (ioctl_wait) wcnt++;
            chk("st_hold_data", mem_data, 8'h22);
            chk("st_hold_addr", mem_addr, 1);
            cyc();
            ioctl_wr = 1'b0;
        end
        chk("st_err", err, 1);
        mem_ready = 1'b1;
        #1;
        if (ioctl_wait) wcnt++;
        chk("st_wait_cycles", wcnt, 3);
        chk("st_we_until_ack", mem_we, 2'b01);
        chk("st_data_ack", mem_data, 8'h22);
        cyc();
        chk("st_we_after_ack", mem_we, 0);
        ioctl_download = 1'b0;
        cyc();
        chk("st_done", load_done, 1);
        chk("st_size", load_size, 2);
        chk("st_err_sticky", err, 1);
        cyc();

        // Reset mid-download, released with download still high
        ioctl_index = 8'd0;
        ioctl_download = 1'b1;
        cyc();
        ioctl_addr = 25'd0; ioctl_dout = 8'h5A; ioctl_wr = 1'b1;
        cyc();
        ioctl_wr = 1'b0;
        chk("rm_pre_we", mem_we, 2'b01);
        reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        chk("rm_rst_we", mem_we, 0);
        chk("rm_rst_active", load_active, 0);
        for (int i = 0; i < 3; i++) begin
            ioctl_addr = 25'(i); ioctl_dout = 8'(i + 1); ioctl_wr = 1'b1;
            cyc();
            chk("rm_ignored_we", mem_we, 0);
            chk("rm_ignored_active", load_active, 0);
        end
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        cyc(2);
        chk("rm_no_done", load_done, 0);
        fill(3);
        run_file(8'd0, 0);

`ifdef IOCTL_LOADER_CHECKSUM_EN
        file.delete();
        file.push_back(8'hFF);
        file.push_back(8'h02);
        run_file(8'd0, 0);
        chk("ck_sum", checksum, 8'h01);
`endif

        // Random files, indices, headers and write gaps
        for (int r = 0; r < 8; r++) begin
            fill($urandom_range(1, 180));
            if (file.size() > 5 && $urandom_range(0, 1) == 1) put_magic();
            run_file(8'($urandom_range(0, 9)), 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
